ram_port_arbiter: RTL and testbench

Shares the single 64x8 single-port on-chip RAM between two requesters: port 0 (HPS-side bridge logic) and port 1 (FPGA annealer engine). It accepts per-port read/write requests over a req/gnt handshake and issues at most one RAM command per cycle. Grants are round-robin. Read data is returned to the originating port with a fixed latency, tagged through a small pipeline. The block sits between the requesters and the RAM's clk/addr/data/we/q pins and owns those pins exclusively.

---
 rtl/ram_port_arbiter.sv | 119 +++++++++++
 tb/tb_ram_port_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// Two-port round-robin front end for a single-port RAM: one command per cycle,
// read data routed back to its requester after RD_LAT cycles via a tag pipeline.
module ram_port_arbiter #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_gnt,
  output logic              r0_rvalid,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_gnt,
  output logic              r1_rvalid,
  output logic [DATA_W-1:0] r1_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_data,
  input  logic [DATA_W-1:0] ram_q,
  output logic              busy,
  output logic [CNT_W-1:0]  gnt_cnt0,
  output logic [CNT_W-1:0]  gnt_cnt1
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  logic              last_grant;
  logic              elig0, elig1;
  logic              pick0, pick1;
  logic [RD_LAT-1:0] tag_vld_p;
  logic [RD_LAT-1:0] tag_port_p;
  logic [DATA_W-1:0] hold0, hold1;

  // A port is masked during its own grant cycle so a held req is not granted twice.
  always_comb begin
    elig0 = r0_req & ~r0_gnt;
    elig1 = r1_req & ~r1_gnt;
    pick0 = elig0 & (~elig1 | last_grant);
    pick1 = elig1 & (~elig0 | ~last_grant);
  end

  // Stage p0: arbitration result registered onto the RAM pins
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r0_gnt     <= 1'b0;
      r1_gnt     <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_data   <= '0;
      last_grant <= 1'b1;
      gnt_cnt0   <= '0;
      gnt_cnt1   <= '0;
    end else begin
      r0_gnt <= pick0;
      r1_gnt <= pick1;
      ram_we <= (pick0 & r0_we) | (pick1 & r1_we);
      if (pick0) begin
        ram_addr   <= r0_addr;
        ram_data   <= r0_wdata;
        last_grant <= 1'b0;
        gnt_cnt0   <= sat_inc(gnt_cnt0);
      end else if (pick1) begin
        ram_addr   <= r1_addr;
        ram_data   <= r1_wdata;
        last_grant <= 1'b1;
        gnt_cnt1   <= sat_inc(gnt_cnt1);
      end
    end
  end

  // Stage p1..pRD_LAT: read tags ride alongside the RAM's own read latency
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tag_vld_p <= '0;
    end else begin
      tag_vld_p[0] <= (r0_gnt | r1_gnt) & ~ram_we;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_vld_p[i] <= tag_vld_p[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    tag_port_p[0] <= r1_gnt;
    for (int i = 1; i < RD_LAT; i++) begin
      tag_port_p[i] <= tag_port_p[i-1];
    end
  end

  assign r0_rvalid = tag_vld_p[RD_LAT-1] & ~tag_port_p[RD_LAT-1];
  assign r1_rvalid = tag_vld_p[RD_LAT-1] &  tag_port_p[RD_LAT-1];
  assign busy      = |tag_vld_p;

  // q is passed straight through on the return cycle; the holding register keeps it afterwards.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hold0 <= '0;
      hold1 <= '0;
    end else begin
      if (r0_rvalid) hold0 <= ram_q;
      if (r1_rvalid) hold1 <= ram_q;
    end
  end

  assign r0_rdata = r0_rvalid ? ram_q : hold0;
  assign r1_rdata = r1_rvalid ? ram_q : hold1;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Randomized bench for ram_port_arbiter against a queue-based reference model
// with a behavioural RAM attached to the RAM pins.
module tb_ram_port_arbiter;
  localparam int ADDR_W = 6;
  localparam int DATA_W = 8;
  localparam int RD_LAT = 2;
  localparam int CNT_W  = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset_n;
  logic [1:0]        req;
  logic [1:0]        we_s;
  logic [ADDR_W-1:0] addr_s [2];
  logic [DATA_W-1:0] wd_s [2];
  logic              r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, ram_we, busy;
  logic [DATA_W-1:0] r0_rdata, r1_rdata, ram_data, ram_q;
  logic [ADDR_W-1:0] ram_addr;
  logic [CNT_W-1:0]  gnt_cnt0, gnt_cnt1;

  ram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .r0_req(req[0]), .r0_we(we_s[0]), .r0_addr(addr_s[0]), .r0_wdata(wd_s[0]),
    .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
    .r1_req(req[1]), .r1_we(we_s[1]), .r1_addr(addr_s[1]), .r1_wdata(wd_s[1]),
    .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_data(ram_data), .ram_q(ram_q),
    .busy(busy), .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
  );

  // Behavioural RAM: read-before-write, q valid RD_LAT cycles after the command.
  logic [DATA_W-1:0] ram_mem [64];
  logic [DATA_W-1:0] q_pipe [RD_LAT];
  always @(posedge clk) begin
    q_pipe[0] <= ram_mem[ram_addr];
    for (int i = 1; i < RD_LAT; i++) q_pipe[i] <= q_pipe[i-1];
    if (ram_we) ram_mem[ram_addr] <= ram_data;
  end
  assign ram_q = q_pipe[RD_LAT-1];

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Reference model: one expected state per clock cycle.
  typedef struct {int g; int due; int port; logic [DATA_W-1:0] d;} rd_t;
  rd_t               pend[$];
  int                cyc = 0;
  logic [1:0]        m_gnt, m_rv;
  logic              m_we, m_lg, m_busy;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_data;
  logic [DATA_W-1:0] m_rd [2];
  int                m_cnt [2];
  logic [DATA_W-1:0] m_mem [64];

  always @(posedge clk) begin : model
    int pick;
    bit e0, e1;
    cyc++;
    if (!reset_n) begin
      m_gnt = 2'b00; m_rv = 2'b00; m_we = 1'b0; m_lg = 1'b1; m_busy = 1'b0;
      m_addr = '0; m_data = '0; m_rd[0] = '0; m_rd[1] = '0;
      m_cnt[0] = 0; m_cnt[1] = 0;
      pend.delete();
    end else begin
      e0 = req[0] && !m_gnt[0];
      e1 = req[1] && !m_gnt[1];
      pick = -1;
      if (e0 && e1) pick = m_lg ? 0 : 1;
      else if (e0) pick = 0;
      else if (e1) pick = 1;
      m_gnt = 2'b00;
      m_we = 1'b0;
      if (pick >= 0) begin
        m_gnt[pick] = 1'b1;
        m_we = we_s[pick];
        m_addr = addr_s[pick];
        m_data = wd_s[pick];
        m_lg = (pick == 1);
        if (m_cnt[pick] < CNT_MAX) m_cnt[pick]++;
        if (we_s[pick]) m_mem[addr_s[pick]] = wd_s[pick];
        else pend.push_back('{cyc, cyc + RD_LAT, pick, m_mem[addr_s[pick]]});
      end
      m_rv = 2'b00;
      m_busy = 1'b0;
      foreach (pend[i]) begin
        if (pend[i].due == cyc) begin
          m_rv[pend[i].port] = 1'b1;
          m_rd[pend[i].port] = pend[i].d;
        end
        if (pend[i].g < cyc && cyc <= pend[i].due) m_busy = 1'b1;
      end
      while (pend.size() > 0 && pend[0].due <= cyc) void'(pend.pop_front());
    end
  end

  bit chk_on = 0;
  always @(negedge clk) begin
    if (chk_on) begin
      chk("r0_gnt",    32'(r0_gnt),    32'(m_gnt[0]));
      chk("r1_gnt",    32'(r1_gnt),    32'(m_gnt[1]));
      chk("ram_we",    32'(ram_we),    32'(m_we));
      chk("ram_addr",  32'(ram_addr),  32'(m_addr));
      chk("ram_data",  32'(ram_data),  32'(m_data));
      chk("r0_rvalid", 32'(r0_rvalid), 32'(m_rv[0]));
      chk("r1_rvalid", 32'(r1_rvalid), 32'(m_rv[1]));
      chk("r0_rdata",  32'(r0_rdata),  32'(m_rd[0]));
      chk("r1_rdata",  32'(r1_rdata),  32'(m_rd[1]));
      chk("busy",      32'(busy),      32'(m_busy));
      chk("gnt_cnt0",  32'(gnt_cnt0),  32'(m_cnt[0]));
      chk("gnt_cnt1",  32'(gnt_cnt1),  32'(m_cnt[1]));
    end
  end

  task automatic set_op(input int p, input logic w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    req[p] = 1'b1;
    we_s[p] = w;
    addr_s[p] = a;
    wd_s[p] = d;
  endtask

  task automatic do_reset();
    req = 2'b00;
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic wait_gnt(input int p);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(p == 0 ? r0_gnt : r1_gnt) && n < 20);
    if (!(p == 0 ? r0_gnt : r1_gnt)) chk("gnt_timeout", 32'(0), 32'(1));
  endtask

  initial begin
    int cnt;
    int diff;
    reset_n = 1'b0;
    req = 2'b00;
    we_s = 2'b00;
    addr_s[0] = '0; addr_s[1] = '0;
    wd_s[0] = '0; wd_s[1] = '0;
    for (int i = 0; i < 64; i++) begin
      ram_mem[i] = DATA_W'(i * 7 + 3);
      m_mem[i] = DATA_W'(i * 7 + 3);
    end
    for (int i = 0; i < RD_LAT; i++) q_pipe[i] = '0;
    @(negedge clk);
    chk_on = 1;

    // Reset held with both reads pending, then continuous contention.
    set_op(0, 1'b0, 6'h01, 8'h00);
    set_op(1, 1'b0, 6'h02, 8'h00);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("first_gnt", 32'({r1_gnt, r0_gnt}), 32'(2'b01));
    repeat (11) @(negedge clk);
    diff = (gnt_cnt0 > gnt_cnt1) ? int'(gnt_cnt0 - gnt_cnt1) : int'(gnt_cnt1 - gnt_cnt0);
    chk("cnt_balance", 32'(diff <= 1), 32'(1));
    req = 2'b00;

    // Write then read back the same address from port 0.
    do_reset();
    set_op(0, 1'b1, 6'h12, 8'hA5);
    wait_gnt(0);
    set_op(0, 1'b0, 6'h12, 8'h00);
    wait_gnt(0);
    req[0] = 1'b0;
    cnt = 0;
    while (!r0_rvalid && cnt < 8) begin
      @(negedge clk);
      cnt++;
    end
    chk("wr_rd_valid", 32'(r0_rvalid), 32'(1));
    chk("wr_rd_data", 32'(r0_rdata), 32'(8'hA5));
    repeat (3) @(negedge clk);

    // Port 1 alone for ten cycles.
    do_reset();
    set_op(1, 1'b0, 6'h03, 8'h00);
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (r1_gnt) cnt++;
    end
    chk("p1_alone_gnts", 32'(cnt), 32'(5));
    req = 2'b00;
    repeat (4) @(negedge clk);

    // Reset lands on the read's grant cycle: the read must vanish.
    do_reset();
    set_op(0, 1'b0, 6'h05, 8'h00);
    wait_gnt(0);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    req = 2'b00;
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (r0_rvalid || r1_rvalid) cnt++;
    end
    chk("flushed_rvalid", 32'(cnt), 32'(0));
    chk("flushed_busy", 32'(busy), 32'(0));

    // Port 0 counter saturation.
    do_reset();
    set_op(0, 1'b1, 6'h09, 8'h3C);
    repeat (40) @(negedge clk);
    chk("cnt0_sat", 32'(gnt_cnt0), 32'(CNT_MAX));
    req = 2'b00;

    // Random traffic with occasional withdrawal and rare resets.
    do_reset();
    repeat (2000) begin
      @(negedge clk);
      if ($urandom_range(0, 299) == 0) begin
        reset_n = 1'b0;
      end else begin
        reset_n = 1'b1;
      end
      for (int p = 0; p < 2; p++) begin
        if (req[p] && (p == 0 ? r0_gnt : r1_gnt)) begin
          if ($urandom_range(0, 1) == 0) req[p] = 1'b0;
          else set_op(p, 1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 7)), DATA_W'($urandom));
        end else if (req[p]) begin
          if ($urandom_range(0, 15) == 0) req[p] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          set_op(p, 1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 7)), DATA_W'($urandom));
        end
      end
    end
    reset_n = 1'b1;
    req = 2'b00;
    repeat (RD_LAT + 4) @(negedge clk);
    chk_on = 0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
